power_sequencer: RTL and testbench

POWER_SEQUENCER -- requirements
Module: power_sequencer

---
 rtl/power_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_power_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/power_sequencer.sv
// Three-stage power rail sequencer: staged bring-up with settle/timeout
// supervision, dropout detection, timed orderly shutdown and latched fault.
module power_sequencer #(
    parameter int unsigned SETTLE_CYCLES  = 1000,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned DOWN_CYCLES    = 1000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_enable,
    input  logic       i_faultClear,
    input  logic       i_S1Good,
    input  logic       i_S2Good,
    input  logic       i_S3Good,
    output logic       o_S1Enable,
    output logic       o_S2Enable,
    output logic       o_S3Enable,
    output logic       o_monitorResetn,
    output logic [3:0] o_state,
    output logic       o_powerGood,
    output logic [1:0] o_faultStage,
    output logic [1:0] o_faultCode
);

    localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned DW = $clog2(DOWN_CYCLES + 1);

    localparam logic [SW-1:0] SETTLE_MAX  = SW'(SETTLE_CYCLES);
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);
    localparam logic [DW-1:0] DOWN_MAX    = DW'(DOWN_CYCLES);

    typedef enum logic [3:0] {
        OFF   = 4'd0,
        EN_S1 = 4'd1,
        EN_S2 = 4'd2,
        EN_S3 = 4'd3,
        ON    = 4'd4,
        SD_S3 = 4'd5,
        SD_S2 = 4'd6,
        SD_S1 = 4'd7,
        FAULT = 4'd8
    } seqStateT;

    seqStateT      state, nextState;
    logic [SW-1:0] settleCnt, settleNext, settleInc;
    logic [TW-1:0] timeoutCnt, timeoutNext, timeoutInc;
    logic [DW-1:0] downCnt, downNext, downInc;
    logic [1:0]    faultStageNext, faultCodeNext;
    logic          stageGood;
    logic          s1EnNext, s2EnNext, s3EnNext;

    assign settleInc  = (settleCnt == SETTLE_MAX)   ? settleCnt  : settleCnt + SW'(1);
    assign timeoutInc = (timeoutCnt == TIMEOUT_MAX) ? timeoutCnt : timeoutCnt + TW'(1);
    assign downInc    = (downCnt == DOWN_MAX)       ? downCnt    : downCnt + DW'(1);

    always_comb begin
        nextState      = state;
        settleNext     = settleCnt;
        timeoutNext    = timeoutCnt;
        downNext       = downCnt;
        faultStageNext = o_faultStage;
        faultCodeNext  = o_faultCode;
        stageGood      = 1'b0;

        case (state)
            EN_S1:   stageGood = i_S1Good;
            EN_S2:   stageGood = i_S2Good;
            EN_S3:   stageGood = i_S3Good;
            default: stageGood = 1'b0;
        endcase

        case (state)
            OFF: begin
                if (i_enable) begin
                    nextState      = EN_S1;
                    faultStageNext = '0;
                    faultCodeNext  = '0;
                end
            end
            EN_S1, EN_S2, EN_S3: begin
                settleNext  = stageGood ? settleInc : '0;
                timeoutNext = timeoutInc;
                // Dropout of an established stage outranks everything else.
                if (state != EN_S1 && !i_S1Good) begin
                    nextState      = FAULT;
                    faultStageNext = 2'd1;
                    faultCodeNext  = 2'd2;
                end else if (state == EN_S3 && !i_S2Good) begin
                    nextState      = FAULT;
                    faultStageNext = 2'd2;
                    faultCodeNext  = 2'd2;
                end else if (!i_enable) begin
                    case (state)
                        EN_S1:   nextState = SD_S1;
                        EN_S2:   nextState = SD_S2;
                        default: nextState = SD_S3;
                    endcase
                end else if (stageGood && settleInc == SETTLE_MAX) begin
                    case (state)
                        EN_S1:   nextState = EN_S2;
                        EN_S2:   nextState = EN_S3;
                        default: nextState = ON;
                    endcase
                end else if (timeoutInc == TIMEOUT_MAX) begin
                    nextState      = FAULT;
                    faultStageNext = state[1:0];
                    faultCodeNext  = 2'd1;
                end
            end
            ON: begin
                if (!i_S1Good || !i_S2Good || !i_S3Good) begin
                    nextState      = FAULT;
                    faultStageNext = !i_S1Good ? 2'd1 : (!i_S2Good ? 2'd2 : 2'd3);
                    faultCodeNext  = 2'd2;
                end else if (!i_enable) begin
                    nextState = SD_S3;
                end
            end
            SD_S3, SD_S2, SD_S1: begin
                downNext = downInc;
                if (downInc == DOWN_MAX) begin
                    case (state)
                        SD_S3:   nextState = SD_S2;
                        SD_S2:   nextState = SD_S1;
                        default: nextState = OFF;
                    endcase
                end
            end
            FAULT: begin
                if (!i_enable && i_faultClear) begin
                    nextState = OFF;
                end
            end
            default: nextState = OFF;
        endcase

        if (nextState != state) begin
            settleNext  = '0;
            timeoutNext = '0;
            downNext    = '0;
        end

        s1EnNext = (nextState != OFF) && (nextState != FAULT);
        s2EnNext = (nextState == EN_S2) || (nextState == EN_S3) || (nextState == ON) ||
                   (nextState == SD_S3) || (nextState == SD_S2);
        s3EnNext = (nextState == EN_S3) || (nextState == ON) || (nextState == SD_S3);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state           <= OFF;
            settleCnt       <= '0;
            timeoutCnt      <= '0;
            downCnt         <= '0;
            o_S1Enable      <= 1'b0;
            o_S2Enable      <= 1'b0;
            o_S3Enable      <= 1'b0;
            o_monitorResetn <= 1'b0;
            o_powerGood     <= 1'b0;
            o_faultStage    <= '0;
            o_faultCode     <= '0;
        end else begin
            state           <= nextState;
            settleCnt       <= settleNext;
            timeoutCnt      <= timeoutNext;
            downCnt         <= downNext;
            o_S1Enable      <= s1EnNext;
            o_S2Enable      <= s2EnNext;
            o_S3Enable      <= s3EnNext;
            o_monitorResetn <= (nextState != OFF);
            o_powerGood     <= (nextState == ON);
            o_faultStage    <= faultStageNext;
            o_faultCode     <= faultCodeNext;
        end
    end

    assign o_state = state;

endmodule

// File: tb/tb_power_sequencer.sv
// Testbench for power_sequencer: directed sequences plus randomized stimulus,
// all checked cycle-by-cycle against a phase/level reference model.
module tb_power_sequencer;

    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 20;
    localparam int DOWN    = 3;

    localparam int M_OFF   = 0;
    localparam int M_UP    = 1;
    localparam int M_ON    = 2;
    localparam int M_DOWN  = 3;
    localparam int M_FAULT = 4;

    logic       clk = 1'b0;
    logic       i_reset = 1'b1, i_enable = 1'b0, i_faultClear = 1'b0;
    logic       i_S1Good = 1'b0, i_S2Good = 1'b0, i_S3Good = 1'b0;
    logic       o_S1Enable, o_S2Enable, o_S3Enable, o_monitorResetn, o_powerGood;
    logic [3:0] o_state;
    logic [1:0] o_faultStage, o_faultCode;

    int errors = 0;
    int checks = 0;

    // Reference model: mode, active stage level, good-run length, elapsed cycles.
    int mMode = M_OFF, mN = 0, mRun = 0, mEl = 0, mFs = 0, mFc = 0;

    power_sequencer #(
        .SETTLE_CYCLES (SETTLE),
        .TIMEOUT_CYCLES(TIMEOUT),
        .DOWN_CYCLES   (DOWN)
    ) dut (
        .i_clk          (clk),
        .i_reset        (i_reset),
        .i_enable       (i_enable),
        .i_faultClear   (i_faultClear),
        .i_S1Good       (i_S1Good),
        .i_S2Good       (i_S2Good),
        .i_S3Good       (i_S3Good),
        .o_S1Enable     (o_S1Enable),
        .o_S2Enable     (o_S2Enable),
        .o_S3Enable     (o_S3Enable),
        .o_monitorResetn(o_monitorResetn),
        .o_state        (o_state),
        .o_powerGood    (o_powerGood),
        .o_faultStage   (o_faultStage),
        .o_faultCode    (o_faultCode)
    );

    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int lowestBad(input int lim);
        logic [3:1] g;
        g = {i_S3Good, i_S2Good, i_S1Good};
        for (int k = 1; k <= lim; k++) if (!g[k]) return k;
        return 0;
    endfunction

    function automatic logic [15:0] modelVec();
        int code;
        logic [3:1] en;
        case (mMode)
            M_OFF:   code = 0;
            M_UP:    code = mN;
            M_ON:    code = 4;
            M_DOWN:  code = 8 - mN;
            default: code = 8;
        endcase
        for (int k = 1; k <= 3; k++)
            en[k] = (mMode == M_ON) || ((mMode == M_UP || mMode == M_DOWN) && mN >= k);
        return {3'b0, 4'(code), en[1], en[2], en[3], 1'(mMode != M_OFF), 1'(mMode == M_ON),
                2'(mFs), 2'(mFc)};
    endfunction

    task automatic modelStep();
        int bad;
        logic [3:1] g;
        g = {i_S3Good, i_S2Good, i_S1Good};
        if (i_reset) begin
            mMode = M_OFF; mN = 0; mRun = 0; mEl = 0; mFs = 0; mFc = 0;
            return;
        end
        case (mMode)
            M_OFF: if (i_enable) begin
                mMode = M_UP; mN = 1; mRun = 0; mEl = 0; mFs = 0; mFc = 0;
            end
            M_UP: begin
                bad = lowestBad(mN - 1);
                if (bad != 0) begin
                    mMode = M_FAULT; mFs = bad; mFc = 2;
                end else if (!i_enable) begin
                    mMode = M_DOWN; mEl = 0;
                end else begin
                    mRun = g[mN] ? mRun + 1 : 0;
                    mEl++;
                    if (mRun == SETTLE) begin
                        if (mN == 3) mMode = M_ON; else mN++;
                        mRun = 0; mEl = 0;
                    end else if (mEl == TIMEOUT) begin
                        mMode = M_FAULT; mFs = mN; mFc = 1;
                    end
                end
            end
            M_ON: begin
                bad = lowestBad(3);
                if (bad != 0) begin
                    mMode = M_FAULT; mFs = bad; mFc = 2;
                end else if (!i_enable) begin
                    mMode = M_DOWN; mN = 3; mEl = 0;
                end
            end
            M_DOWN: begin
                mEl++;
                if (mEl == DOWN) begin
                    mEl = 0; mN--;
                    if (mN == 0) mMode = M_OFF;
                end
            end
            default: if (!i_enable && i_faultClear) mMode = M_OFF;
        endcase
    endtask

    function automatic logic [15:0] dutVec();
        return {3'b0, o_state, o_S1Enable, o_S2Enable, o_S3Enable, o_monitorResetn,
                o_powerGood, o_faultStage, o_faultCode};
    endfunction

    task automatic tick();
        @(posedge clk);
        modelStep();
        #1;
        checkEq("cycle", dutVec(), modelVec());
    endtask

    task automatic doReset();
        i_reset = 1'b1; i_enable = 1'b0; i_faultClear = 1'b0;
        tick();
        i_reset = 1'b0;
    endtask

    task automatic waitState(input logic [3:0] s, input int limit, input string tag);
        for (int n = 0; n < limit && o_state != s; n++) tick();
        checkEq(tag, 16'(o_state), 16'(s));
    endtask

    initial begin
        logic [1:0]  h1, h2, h3;
        logic [19:0] seq;
        int          n;
        int          goodPct;
        int          sdExp[10] = '{5, 5, 5, 6, 6, 6, 7, 7, 7, 0};
        logic        pat[8]    = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

        // Power-up with goods following their enables two cycles late.
        tick();
        doReset();
        checkEq("reset_vec", dutVec(), 16'h0000);
        i_enable = 1'b1;
        h1 = '0; h2 = '0; h3 = '0;
        seq = 20'h0;
        for (n = 0; n < 80 && o_state != 4'd4; n++) begin
            tick();
            if (o_state != seq[3:0]) seq = {seq[15:0], o_state};
            h1 = {h1[0], o_S1Enable}; h2 = {h2[0], o_S2Enable}; h3 = {h3[0], o_S3Enable};
            i_S1Good = h1[1]; i_S2Good = h2[1]; i_S3Good = h3[1];
        end
        checkEq("bringup_seq", seq[15:0], 16'h1234);
        checkEq("bringup_pg", 16'(o_powerGood), 16'd1);

        // Orderly shutdown timing from ON.
        i_enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checkEq("shutdown_state", 16'(o_state), 16'(sdExp[i]));
        end

        // Timeout in EN_S2.
        doReset();
        i_S1Good = 1'b1; i_S2Good = 1'b0; i_S3Good = 1'b0; i_enable = 1'b1;
        waitState(4'd2, 40, "reach_en_s2");
        n = 0;
        while (o_state == 4'd2 && n < 100) begin tick(); n++; end
        checkEq("timeout_len", 16'(n), 16'd20);
        checkEq("timeout_fault", {12'h0, o_faultStage, o_faultCode}, 16'h0009);
        checkEq("timeout_en", {13'h0, o_S1Enable, o_S2Enable, o_S3Enable}, 16'h0000);

        // Dropout of S1 and S3 together in ON, then fault clear handshake.
        doReset();
        i_S1Good = 1'b1; i_S2Good = 1'b1; i_S3Good = 1'b1; i_enable = 1'b1;
        waitState(4'd4, 60, "reach_on");
        i_S1Good = 1'b0; i_S3Good = 1'b0;
        tick();
        i_S1Good = 1'b1; i_S3Good = 1'b1;
        checkEq("dropout_state", 16'(o_state), 16'd8);
        checkEq("dropout_fault", {12'h0, o_faultStage, o_faultCode}, 16'h0006);
        i_faultClear = 1'b1;
        tick();
        checkEq("fault_hold", 16'(o_state), 16'd8);
        i_enable = 1'b0;
        tick();
        checkEq("fault_clear", 16'(o_state), 16'd0);
        checkEq("fault_kept_off", {12'h0, o_faultStage, o_faultCode}, 16'h0006);
        i_faultClear = 1'b0;

        // Settle counter restarts on a bad sample in EN_S3.
        doReset();
        i_S1Good = 1'b1; i_S2Good = 1'b1; i_S3Good = 1'b0; i_enable = 1'b1;
        waitState(4'd3, 60, "reach_en_s3");
        for (int i = 0; i < 8; i++) begin
            i_S3Good = pat[i];
            tick();
            checkEq("settle_restart", 16'(o_state), (i == 7) ? 16'd4 : 16'd3);
        end

        // Reset during SD_S2.
        doReset();
        i_S1Good = 1'b1; i_S2Good = 1'b1; i_S3Good = 1'b1; i_enable = 1'b1;
        waitState(4'd4, 60, "reach_on2");
        i_enable = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checkEq("in_sd_s2", 16'(o_state), 16'd6);
        i_reset = 1'b1;
        tick();
        checkEq("reset_mid_sd", dutVec(), 16'h0000);
        i_reset = 1'b0;

        // Randomized segments with varying rail quality.
        for (int seg = 0; seg < 16; seg++) begin
            case (seg % 4)
                0:       goodPct = 100;
                1:       goodPct = 98;
                2:       goodPct = 90;
                default: goodPct = 60;
            endcase
            for (int c = 0; c < 200; c++) begin
                if ($urandom_range(39) == 0) i_enable = ~i_enable;
                i_S1Good     = ($urandom_range(99) < goodPct);
                i_S2Good     = ($urandom_range(99) < goodPct);
                i_S3Good     = ($urandom_range(99) < goodPct);
                i_faultClear = ($urandom_range(7) == 0);
                i_reset      = ($urandom_range(299) == 0);
                tick();
            end
        end
        i_reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
